// File: rtl/pipeline_width_reducer_if.sv
// Ready/valid bundle between the pipeline FIFO output and the width reducer.
// output_last exists only when PIPELINE_WIDTH_REDUCER_LAST_EN is defined.
interface pipeline_width_reducer_if #(
    parameter int WORD_WIDTH_OUT = 8,
    parameter int RATIO          = 4
);
    localparam int WORD_WIDTH_IN = WORD_WIDTH_OUT * RATIO;

    logic                      input_valid;
    logic                      input_ready;
    logic [WORD_WIDTH_IN-1:0]  input_data;
    logic                      output_valid;
    logic                      output_ready;
    logic [WORD_WIDTH_OUT-1:0] output_data;
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
    logic                      output_last;
`endif

    // The reducer itself: consumes wide words, produces narrow slices.
    modport slave (
        input  input_valid,
        output input_ready,
        input  input_data,
        output output_valid,
        input  output_ready,
        output output_data
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
        ,
        output output_last
`endif
    );

    modport master (
        output input_valid,
        input  input_ready,
        output input_data,
        input  output_valid,
        output output_ready,
        input  output_data
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
        ,
        input  output_last
`endif
    );
endinterface

// File: rtl/pipeline_width_reducer.sv
// Splits each wide input word into RATIO narrow slices, slice 0 first, one per cycle.
// Optional output_last port is enabled by defining PIPELINE_WIDTH_REDUCER_LAST_EN.
module pipeline_width_reducer #(
    parameter int WORD_WIDTH_OUT = 8,   // >= 1
    parameter int RATIO          = 4    // >= 2, any integer
) (
    input  logic                    clock,
    input  logic                    clear,
    pipeline_width_reducer_if.slave bus
);
    localparam int WORD_WIDTH_IN = WORD_WIDTH_OUT * RATIO;
    localparam int COUNT_WIDTH   = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(RATIO - 1);

    logic [WORD_WIDTH_IN-1:0] r_staging;
    logic                     r_staging_valid;
    logic [WORD_WIDTH_IN-1:0] r_shift;
    logic                     r_shift_valid;
    logic [COUNT_WIDTH-1:0]   r_count;

    logic w_in_fire;
    logic w_out_fire;
    logic w_last_slice;
    logic w_load;

    assign w_in_fire    = bus.input_valid & ~r_staging_valid;
    assign w_out_fire   = r_shift_valid & bus.output_ready;
    assign w_last_slice = (r_count == LAST_COUNT);
    // Refill the shift register when it is empty or its last slice leaves this cycle.
    assign w_load       = r_staging_valid & (~r_shift_valid | (w_out_fire & w_last_slice));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make update order change the logic.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_staging_valid <= 1'b0;
            r_shift_valid   <= 1'b0;
            r_shift         <= '0;
            r_count         <= '0;
        end else begin
            if (w_in_fire) begin
                r_staging_valid <= 1'b1;
            end else if (w_load) begin
                r_staging_valid <= 1'b0;
            end

            if (w_load) begin
                r_shift       <= r_staging;
                r_shift_valid <= 1'b1;
                r_count       <= '0;
            end else if (w_out_fire) begin
                if (w_last_slice) begin
                    r_shift_valid <= 1'b0;
                    r_count       <= '0;
                end else begin
                    r_shift <= r_shift >> WORD_WIDTH_OUT;
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    // NOTE: the staging data register has no reset; r_staging_valid alone qualifies it.
    always_ff @(posedge clock) begin
        if (w_in_fire) begin
            r_staging <= bus.input_data;
        end
    end

    assign bus.input_ready  = ~r_staging_valid;
    assign bus.output_valid = r_shift_valid;
    assign bus.output_data  = r_shift[WORD_WIDTH_OUT-1:0];

`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
    assign bus.output_last  = r_shift_valid & w_last_slice;
`endif

endmodule

// File: tb/tb_pipeline_width_reducer.sv
// Bench for pipeline_width_reducer: directed cases on RATIO=4 and RATIO=3 instances,
// then random traffic checked against a slice-queue reference model.
module tb_pipeline_width_reducer;
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } slice_t;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    pipeline_width_reducer_if #(.WORD_WIDTH_OUT(8), .RATIO(4)) bus4 ();
    pipeline_width_reducer_if #(.WORD_WIDTH_OUT(8), .RATIO(3)) bus3 ();

    pipeline_width_reducer #(.WORD_WIDTH_OUT(8), .RATIO(4)) u_dut4 (
        .clock (clock),
        .clear (clear),
        .bus   (bus4)
    );
    pipeline_width_reducer #(.WORD_WIDTH_OUT(8), .RATIO(3)) u_dut3 (
        .clock (clock),
        .clear (clear),
        .bus   (bus3)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Expected slice streams: each accepted word becomes RATIO entries, low slice first.
    slice_t q4[$];
    slice_t q3[$];

    logic       prev_v [2] = '{1'b0, 1'b0};
    logic       prev_r [2] = '{1'b0, 1'b0};
    logic [7:0] prev_d [2] = '{8'h00, 8'h00};

    logic       s_valid    [2];
    logic       s_in_ready [2];
    logic [7:0] s_data     [2];
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
    logic       s_last     [2];
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive4(input logic v, input logic [31:0] d, input logic r);
        bus4.input_valid  = v;
        bus4.input_data   = d;
        bus4.output_ready = r;
    endtask

    task automatic drive3(input logic v, input logic [23:0] d, input logic r);
        bus3.input_valid  = v;
        bus3.input_data   = d;
        bus3.output_ready = r;
    endtask

    task automatic model(input int sel);
        int          ratio;
        int          sz;
        slice_t      front;
        slice_t      s;
        logic        in_v;
        logic        o_r;
        logic [31:0] in_d;
        ratio = (sel != 0) ? 3 : 4;
        in_v  = (sel != 0) ? bus3.input_valid  : bus4.input_valid;
        o_r   = (sel != 0) ? bus3.output_ready : bus4.output_ready;
        in_d  = (sel != 0) ? 32'(bus3.input_data) : bus4.input_data;
        if (clear) begin
            if (sel != 0) q3.delete(); else q4.delete();
            prev_v[sel] = 1'b0;
            return;
        end
        sz = (sel != 0) ? q3.size() : q4.size();
        if (prev_v[sel] && !prev_r[sel]) begin
            check("stall_valid_hold", 32'(s_valid[sel]), 32'd1);
            check("stall_data_hold", 32'(s_data[sel]), 32'(prev_d[sel]));
        end
        if (s_valid[sel]) begin
            check("model_has_slice", 32'(sz != 0), 32'd1);
            if (sz != 0) begin
                front = (sel != 0) ? q3[0] : q4[0];
                check("model_data", 32'(s_data[sel]), 32'(front.data));
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
                check("model_last", 32'(s_last[sel]), 32'(front.last));
`endif
                if (o_r) begin
                    if (sel != 0) void'(q3.pop_front()); else void'(q4.pop_front());
                end
            end
        end
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
        else begin
            check("model_last_idle", 32'(s_last[sel]), 32'd0);
        end
`endif
        if (in_v && s_in_ready[sel]) begin
            for (int k = 0; k < ratio; k++) begin
                s.data = in_d[8*k +: 8];
                s.last = (k == ratio - 1);
                if (sel != 0) q3.push_back(s); else q4.push_back(s);
            end
        end
        prev_v[sel] = s_valid[sel];
        prev_r[sel] = o_r;
        prev_d[sel] = s_data[sel];
    endtask

    // One clock cycle: inputs already driven, outputs sampled at the falling edge.
    task automatic cycle();
        @(negedge clock);
        s_valid[0]    = bus4.output_valid;
        s_data[0]     = bus4.output_data;
        s_in_ready[0] = bus4.input_ready;
        s_valid[1]    = bus3.output_valid;
        s_data[1]     = bus3.output_data;
        s_in_ready[1] = bus3.input_ready;
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
        s_last[0]     = bus4.output_last;
        s_last[1]     = bus3.output_last;
`endif
        model(0);
        model(1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w4 [2];
        logic [23:0] w3 [2];
        int          nw;

        w4[0] = 32'h44332211;
        w4[1] = 32'h88776655;
        w3[0] = 24'h332211;
        w3[1] = 24'h665544;

        // Reset
        clear = 1'b1;
        drive4(1'b0, 32'h0, 1'b1);
        drive3(1'b0, 24'h0, 1'b1);
        cycle();
        cycle();
        clear = 1'b0;
        cycle();
        check("rst_in_ready4", 32'(s_in_ready[0]), 32'd1);
        check("rst_valid4", 32'(s_valid[0]), 32'd0);
        check("rst_data4", 32'(s_data[0]), 32'd0);
        check("rst_in_ready3", 32'(s_in_ready[1]), 32'd1);
        check("rst_valid3", 32'(s_valid[1]), 32'd0);
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
        check("rst_last4", 32'(s_last[0]), 32'd0);
`endif

        // Single word: slices in cycles 2..5
        drive4(1'b1, w4[0], 1'b1);
        cycle();
        check("sw_accept", 32'(s_in_ready[0]), 32'd1);
        drive4(1'b0, 32'h0, 1'b1);
        cycle();
        check("sw_latency_valid", 32'(s_valid[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("sw_valid", 32'(s_valid[0]), 32'd1);
            check("sw_data", 32'(s_data[0]), 32'(17 * (i + 1)));
        end
        cycle();
        check("sw_done_valid", 32'(s_valid[0]), 32'd0);

        // Back-to-back words: eight slices without a gap
        nw = 0;
        for (int k = 0; k <= 10; k++) begin
            if (nw < 2) drive4(1'b1, w4[nw], 1'b1);
            else        drive4(1'b0, 32'h0, 1'b1);
            cycle();
            if (bus4.input_valid && s_in_ready[0]) nw++;
            if (k >= 2 && k <= 9) begin
                check("b2b_valid", 32'(s_valid[0]), 32'd1);
                check("b2b_data", 32'(s_data[0]), 32'(17 * (k - 1)));
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
                check("b2b_last", 32'(s_last[0]), 32'(k == 5 || k == 9));
`endif
            end else begin
                check("b2b_idle_valid", 32'(s_valid[0]), 32'd0);
            end
        end
        check("b2b_words_accepted", 32'(nw), 32'd2);

        // Backpressure: hold 0x11 with a second word staged, then release
        nw = 0;
        for (int k = 0; k <= 14; k++) begin
            if (nw < 2) drive4(1'b1, w4[nw], k >= 6);
            else        drive4(1'b0, 32'h0, k >= 6);
            cycle();
            if (bus4.input_valid && s_in_ready[0]) nw++;
            if (k >= 2 && k <= 5) begin
                check("bp_hold_valid", 32'(s_valid[0]), 32'd1);
                check("bp_hold_data", 32'(s_data[0]), 32'h11);
            end
            if (k >= 3 && k <= 5) check("bp_in_ready_low", 32'(s_in_ready[0]), 32'd0);
            if (k >= 6 && k <= 13) begin
                check("bp_resume_valid", 32'(s_valid[0]), 32'd1);
                check("bp_resume_data", 32'(s_data[0]), 32'(17 * (k - 5)));
            end
            if (k == 14) check("bp_done_valid", 32'(s_valid[0]), 32'd0);
        end

        // Mid-word clear after 0x22, with a competing input word that must be dropped
        drive4(1'b1, w4[0], 1'b1);
        cycle();
        drive4(1'b0, 32'h0, 1'b1);
        cycle();
        cycle();
        check("mc_data_11", 32'(s_data[0]), 32'h11);
        cycle();
        check("mc_data_22", 32'(s_data[0]), 32'h22);
        clear = 1'b1;
        drive4(1'b1, 32'hDEADBEEF, 1'b1);
        cycle();
        clear = 1'b0;
        drive4(1'b1, 32'hDDCCBBAA, 1'b1);
        cycle();
        check("mc_valid_cleared", 32'(s_valid[0]), 32'd0);
        check("mc_in_ready", 32'(s_in_ready[0]), 32'd1);
        check("mc_data_zero", 32'(s_data[0]), 32'd0);
        drive4(1'b0, 32'h0, 1'b1);
        cycle();
        check("mc_latency_valid", 32'(s_valid[0]), 32'd0);
        cycle();
        check("mc_first_valid", 32'(s_valid[0]), 32'd1);
        check("mc_first_data", 32'(s_data[0]), 32'hAA);
        for (int i = 0; i < 4; i++) cycle();
        check("mc_done_valid", 32'(s_valid[0]), 32'd0);

        // RATIO=3: two words back-to-back, counter wraps between them
        nw = 0;
        for (int k = 0; k <= 8; k++) begin
            if (nw < 2) drive3(1'b1, w3[nw], 1'b1);
            else        drive3(1'b0, 24'h0, 1'b1);
            cycle();
            if (bus3.input_valid && s_in_ready[1]) nw++;
            if (k >= 2 && k <= 7) begin
                check("r3_valid", 32'(s_valid[1]), 32'd1);
                check("r3_data", 32'(s_data[1]), 32'(17 * (k - 1)));
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
                check("r3_last", 32'(s_last[1]), 32'(k == 4 || k == 7));
`endif
            end else begin
                check("r3_idle_valid", 32'(s_valid[1]), 32'd0);
            end
        end

        // Random traffic on both instances with occasional clears
        for (int n = 0; n < 600; n++) begin
            clear = ($urandom_range(0, 99) == 0);
            drive4($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 3) != 0);
            drive3($urandom_range(0, 3) != 0, 24'($urandom()), $urandom_range(0, 3) != 0);
            cycle();
        end

        // Drain with a bounded cycle budget
        clear = 1'b0;
        drive4(1'b0, 32'h0, 1'b1);
        drive3(1'b0, 24'h0, 1'b1);
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (q4.size() == 0 && q3.size() == 0 && !s_valid[0] && !s_valid[1]) break;
        end
        check("drain_q4_empty", 32'(q4.size()), 32'd0);
        check("drain_q3_empty", 32'(q3.size()), 32'd0);
        check("drain_valid4", 32'(s_valid[0]), 32'd0);
        check("drain_valid3", 32'(s_valid[1]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
